// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and prefix-state type for the PS/2 key tracker
// Contents: prefix byte values, maximum tracked key count, prefix FSM state enum.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_MAX_KEYS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_prefix_fsm.sv
// rtl/ps2_prefix_fsm.sv - PS/2 set-2 prefix decoder (E0 / F0) producing qualified code bytes
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   scan_done_tick       byte strobe from the PS/2 receiver
//   scan_code[7:0]       received byte
//   code_valid           high in the same cycle as a non-prefix byte tick
//   code_ext, code_brk   prefix context that applies to code_byte
//   code_byte[7:0]       the code byte itself
module ps2_prefix_fsm
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  output logic       code_valid,
  output logic       code_ext,
  output logic       code_brk,
  output logic [7:0] code_byte
);

  ps2_state_e state_q, state_d;

  // Outputs are combinational so the key array can register its update in
  // the cycle right after the code byte tick.
  always_comb begin
    state_d    = state_q;
    code_valid = 1'b0;
    code_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    code_brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    code_byte  = scan_code;
    if (scan_done_tick) begin
      if (scan_code == PS2_EXT_PREFIX) begin
        // E0 restarts the sequence; an earlier F0 is dropped.
        state_d = ST_EXT;
      end else if (scan_code == PS2_BREAK_PREFIX) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        code_valid = 1'b1;
        state_d    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - held/released tracker with press/release pulses for NUM_KEYS programmable keys
// Config macro: PS2_TYPEMATIC_EN (press_tick also pulses on repeated makes of a held key).
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   scan_done_tick, scan_code byte stream from the PS/2 receiver
//   key_codes[8*NUM_KEYS]     per-key scan code, key i at [8i+7:8i]
//   key_ext[NUM_KEYS]         per-key E0-prefix requirement
//   key_down[NUM_KEYS]        held state
//   press_tick, release_tick  one-cycle make/break event pulses
//   any_down                  registered OR of key_down
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_KEYS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scan_done_tick,
  input  logic [7:0]            scan_code,
  input  logic [8*NUM_KEYS-1:0] key_codes,
  input  logic [NUM_KEYS-1:0]   key_ext,
  output logic [NUM_KEYS-1:0]   key_down,
  output logic [NUM_KEYS-1:0]   press_tick,
  output logic [NUM_KEYS-1:0]   release_tick,
  output logic                  any_down
);

`ifdef PS2_TYPEMATIC_EN
  localparam logic TYPEMATIC = 1'b1;
`else
  localparam logic TYPEMATIC = 1'b0;
`endif

  logic       code_valid;
  logic       code_ext;
  logic       code_brk;
  logic [7:0] code_byte;

  ps2_prefix_fsm u_prefix_fsm (
    .clk            (clk),
    .reset_n        (reset_n),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .code_valid     (code_valid),
    .code_ext       (code_ext),
    .code_brk       (code_brk),
    .code_byte      (code_byte)
  );

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] press_tick_q, press_tick_d;
  logic [NUM_KEYS-1:0] release_tick_q, release_tick_d;
  logic                any_down_q, any_down_d;

  // Duplicate code/ext entries match together, so every slot compares
  // independently.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    assign match[i] = code_valid
                   && (key_codes[8*i +: 8] == code_byte)
                   && (key_ext[i] == code_ext);
  end

  always_comb begin
    key_down_d     = key_down_q;
    press_tick_d   = '0;
    release_tick_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (match[i]) begin
        key_down_d[i]     = !code_brk;
        press_tick_d[i]   = !code_brk && (TYPEMATIC || !key_down_q[i]);
        release_tick_d[i] = code_brk && key_down_q[i];
      end
    end
    // Built from the registered key state, hence one cycle behind key_down.
    any_down_d = |key_down_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_down_q     <= '0;
      press_tick_q   <= '0;
      release_tick_q <= '0;
      any_down_q     <= 1'b0;
    end else begin
      key_down_q     <= key_down_d;
      press_tick_q   <= press_tick_d;
      release_tick_q <= release_tick_d;
      any_down_q     <= any_down_d;
    end
  end

  assign key_down     = key_down_q;
  assign press_tick   = press_tick_q;
  assign release_tick = release_tick_q;
  assign any_down     = any_down_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - self-checking bench for ps2_key_tracker with a byte-level reference model
module tb_ps2_key_tracker;

  localparam int NK = 4;

`ifdef PS2_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            scan_done_tick = 1'b0;
  logic [7:0]      scan_code = 8'h00;
  logic [8*NK-1:0] key_codes;
  logic [NK-1:0]   key_ext;
  logic [NK-1:0]   key_down;
  logic [NK-1:0]   press_tick;
  logic [NK-1:0]   release_tick;
  logic            any_down;

  localparam logic [8*NK-1:0] DEF_CODES = {8'h75, 8'h23, 8'h1C, 8'h1D};
  localparam logic [NK-1:0]   DEF_EXT   = 4'b1000;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: prefix context as two flags, key state as a vector.
  bit          m_ext, m_brk;
  bit [NK-1:0] m_down, m_press, m_rel;
  bit          m_any;

  ps2_key_tracker #(.NUM_KEYS(NK)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .key_codes      (key_codes),
    .key_ext        (key_ext),
    .key_down       (key_down),
    .press_tick     (press_tick),
    .release_tick   (release_tick),
    .any_down       (any_down)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_down = '0; m_press = '0; m_rel = '0; m_any = 0;
  endtask

  task automatic model_byte(input bit tick, input logic [7:0] code);
    m_any   = |m_down;
    m_press = '0;
    m_rel   = '0;
    if (tick) begin
      if (code == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (code == 8'hF0) begin
        m_brk = 1;
      end else begin
        for (int k = 0; k < NK; k++) begin
          if (key_codes[8*k +: 8] == code && key_ext[k] == m_ext) begin
            if (m_brk) begin
              m_rel[k]  = m_down[k];
              m_down[k] = 0;
            end else begin
              m_press[k] = TYP || !m_down[k];
              m_down[k]  = 1;
            end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  // One clock: present a byte (or idle), advance the model, return at edge+1.
  task automatic step(input bit tick, input logic [7:0] code);
    @(negedge clk);
    scan_done_tick = tick;
    scan_code      = code;
    @(posedge clk);
    if (reset_n) model_byte(tick, code);
    #1;
    scan_done_tick = 1'b0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    key_codes = DEF_CODES;
    key_ext   = DEF_EXT;
    @(negedge clk);
    reset_n = 1'b0;
    scan_done_tick = 1'b1;
    scan_code = 8'h1D;
    @(posedge clk);
    model_reset();
    #1;
    scan_done_tick = 1'b0;
    n_checks++;
    if (key_down !== 4'b0000) $display("FAIL reset_key_down got=%b exp=0000", key_down); else n_pass++;
    n_checks++;
    if (press_tick !== 4'b0000 || release_tick !== 4'b0000)
      $display("FAIL reset_ticks press=%b release=%b exp=0000", press_tick, release_tick);
    else n_pass++;
    n_checks++;
    if (any_down !== 1'b0) $display("FAIL reset_any_down got=%b exp=0", any_down); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 8'h00);
    n_checks++;
    if (key_down !== 4'b0000) $display("FAIL reset_priority got=%b exp=0000", key_down); else n_pass++;
  endtask

  task automatic test_make_break();
    step(1, 8'h1D);
    n_checks++;
    if (key_down !== 4'b0001 || press_tick !== 4'b0001 || any_down !== 1'b0)
      $display("FAIL make_1d down=%b press=%b any=%b exp=0001/0001/0", key_down, press_tick, any_down);
    else n_pass++;
    step(0, 8'h00);
    n_checks++;
    if (press_tick !== 4'b0000 || any_down !== 1'b1)
      $display("FAIL make_1d_next press=%b any=%b exp=0000/1", press_tick, any_down);
    else n_pass++;
    step(1, 8'hF0);
    n_checks++;
    if (key_down !== 4'b0001 || release_tick !== 4'b0000)
      $display("FAIL prefix_f0_quiet down=%b release=%b exp=0001/0000", key_down, release_tick);
    else n_pass++;
    step(1, 8'h1D);
    n_checks++;
    if (key_down !== 4'b0000 || release_tick !== 4'b0001 || any_down !== 1'b1)
      $display("FAIL break_1d down=%b release=%b any=%b exp=0000/0001/1", key_down, release_tick, any_down);
    else n_pass++;
    step(0, 8'h00);
    n_checks++;
    if (release_tick !== 4'b0000 || any_down !== 1'b0)
      $display("FAIL break_1d_next release=%b any=%b exp=0000/0", release_tick, any_down);
    else n_pass++;
  endtask

  task automatic test_extended();
    step(1, 8'h75);
    n_checks++;
    if (key_down !== 4'b0000) $display("FAIL plain_75 got=%b exp=0000", key_down); else n_pass++;
    step(1, 8'hE0);
    step(1, 8'h75);
    n_checks++;
    if (key_down !== 4'b1000 || press_tick !== 4'b1000)
      $display("FAIL ext_make down=%b press=%b exp=1000/1000", key_down, press_tick);
    else n_pass++;
    step(1, 8'hE0);
    step(1, 8'hF0);
    step(1, 8'h75);
    n_checks++;
    if (key_down !== 4'b0000 || release_tick !== 4'b1000)
      $display("FAIL ext_break down=%b release=%b exp=0000/1000", key_down, release_tick);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int presses = 0;
    step(1, 8'h1C); presses += press_tick[1];
    step(1, 8'h1C); presses += press_tick[1];
    step(1, 8'h1C); presses += press_tick[1];
    step(0, 8'h00); presses += press_tick[1];
    n_checks++;
    if (presses != (TYP ? 3 : 1)) $display("FAIL typematic_count got=%0d exp=%0d", presses, TYP ? 3 : 1);
    else n_pass++;
    n_checks++;
    if (key_down !== 4'b0010) $display("FAIL typematic_down got=%b exp=0010", key_down); else n_pass++;
    step(1, 8'hF0);
    step(1, 8'h1C);
    step(0, 8'h00);
  endtask

  task automatic test_multi_key();
    step(1, 8'h1D);
    step(1, 8'h1C);
    n_checks++;
    if (key_down !== 4'b0011) $display("FAIL multi_two_down got=%b exp=0011", key_down); else n_pass++;
    step(1, 8'hF0);
    step(1, 8'h1C);
    n_checks++;
    if (key_down !== 4'b0001) $display("FAIL multi_release_1c got=%b exp=0001", key_down); else n_pass++;
    step(1, 8'h2B);
    n_checks++;
    if (key_down !== 4'b0001 || press_tick !== 4'b0000 || release_tick !== 4'b0000)
      $display("FAIL unmatched_2b down=%b press=%b release=%b exp=0001/0000/0000", key_down, press_tick, release_tick);
    else n_pass++;
  endtask

  task automatic test_double_break();
    int rels = 0;
    step(1, 8'hF0); rels += release_tick[0];
    step(1, 8'hF0); rels += release_tick[0];
    step(1, 8'h1D); rels += release_tick[0];
    step(0, 8'h00); rels += release_tick[0];
    n_checks++;
    if (rels != 1 || key_down[0] !== 1'b0)
      $display("FAIL double_f0 releases=%0d down0=%b exp=1/0", rels, key_down[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_prefix();
    step(1, 8'hE0);
    rst_pulse();
    step(1, 8'h75);
    n_checks++;
    if (key_down !== 4'b0000) $display("FAIL reset_drops_e0 got=%b exp=0000", key_down); else n_pass++;
    step(1, 8'hF0);
    rst_pulse();
    step(1, 8'h1D);
    n_checks++;
    if (key_down !== 4'b0001 || press_tick !== 4'b0001)
      $display("FAIL reset_drops_f0 down=%b press=%b exp=0001/0001", key_down, press_tick);
    else n_pass++;
    rst_pulse();
  endtask

  task automatic test_f0_then_e0();
    step(1, 8'hF0);
    step(1, 8'hE0);
    step(1, 8'h75);
    n_checks++;
    if (key_down !== 4'b1000 || press_tick !== 4'b1000)
      $display("FAIL f0_e0_make down=%b press=%b exp=1000/1000", key_down, press_tick);
    else n_pass++;
    rst_pulse();
  endtask

  task automatic test_code_change();
    step(1, 8'h1D);
    key_codes[7:0] = 8'h2B;
    step(0, 8'h00);
    n_checks++;
    if (key_down[0] !== 1'b1) $display("FAIL remap_hold got=%b exp=1", key_down[0]); else n_pass++;
    step(1, 8'hF0);
    step(1, 8'h1D);
    n_checks++;
    if (key_down[0] !== 1'b1) $display("FAIL remap_old_break got=%b exp=1", key_down[0]); else n_pass++;
    step(1, 8'hF0);
    step(1, 8'h2B);
    n_checks++;
    if (key_down[0] !== 1'b0 || release_tick[0] !== 1'b1)
      $display("FAIL remap_new_break down=%b release=%b exp=0/1", key_down[0], release_tick[0]);
    else n_pass++;
    key_codes = DEF_CODES;
    step(0, 8'h00);
  endtask

  task automatic test_duplicate();
    key_codes[23:16] = 8'h1D;
    step(1, 8'h1D);
    n_checks++;
    if (key_down !== 4'b0101 || press_tick !== 4'b0101)
      $display("FAIL dup_make down=%b press=%b exp=0101/0101", key_down, press_tick);
    else n_pass++;
    step(1, 8'hF0);
    step(1, 8'h1D);
    n_checks++;
    if (key_down !== 4'b0000 || release_tick !== 4'b0101)
      $display("FAIL dup_break down=%b release=%b exp=0000/0101", key_down, release_tick);
    else n_pass++;
    key_codes = DEF_CODES;
    step(0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    int errs = 0;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1D; pool[3] = 8'h1C;
    pool[4] = 8'h23; pool[5] = 8'h75; pool[6] = 8'h2B; pool[7] = 8'h00;
    for (int c = 0; c < 600; c++) begin
      logic [7:0] b;
      bit t;
      b = pool[$urandom_range(7)];
      if (b == 8'h00) b = 8'($urandom);
      t = ($urandom_range(9) < 7);
      if ($urandom_range(99) == 0) begin
        rst_pulse();
        continue;
      end
      step(t, b);
      n_checks++;
      if (key_down !== m_down || press_tick !== m_press || release_tick !== m_rel || any_down !== m_any) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d down=%b/%b press=%b/%b release=%b/%b any=%b/%b (got/exp)",
                   c, key_down, m_down, press_tick, m_press, release_tick, m_rel, any_down, m_any);
        errs++;
      end else n_pass++;
      n_checks++;
      if ((press_tick & release_tick) !== 4'b0000)
        $display("FAIL random_overlap%0d press=%b release=%b exp_and=0000", c, press_tick, release_tick);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_back_to_back();
    test_multi_key();
    test_double_break();
    test_reset_mid_prefix();
    test_f0_then_e0();
    test_code_change();
    test_duplicate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 scan-code set 2 key-state tracker. It sits directly after the PS/2 receiver, consuming its byte stream (`scan_code`, `scan_done_tick`). It tracks held/released state for `NUM_KEYS` runtime-programmable keys, including E0-prefixed extended keys. Per-key press/release event pulses go to game and control logic.

## Interface
- `NUM_KEYS`, default 4: number of tracked keys, range 1..16.
- `clk`  in  1: system clock; single clock domain.
- `reset_n`  in  1: synchronous, active-low reset.
- `scan_done_tick`  in  1: one-cycle strobe; `scan_code` is valid this cycle.
- `scan_code`  in  8: received byte.
- `key_codes`  in  8*NUM_KEYS: key i code at bits [8i+7:8i]; quasi-static.
- `key_ext`  in  NUM_KEYS: bit i set means key i requires the E0 prefix.
- `key_down`  out  NUM_KEYS: bit i high while key i is held.
- `press_tick`  out  NUM_KEYS: one-cycle pulse on key i make.
- `release_tick`  out  NUM_KEYS: one-cycle pulse on key i break.
- `any_down`  out  1: OR of `key_down`, registered.

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). It advances only on `scan_done_tick`.
- State transitions:
  - E0 from any state goes to EXT; any pending break is discarded.
  - F0 from IDLE goes to BRK; F0 from EXT goes to EXT_BRK; F0 in BRK or EXT_BRK stays in the current state.
  - Any other byte is a code byte. The FSM evaluates it, then returns to IDLE.
- Code byte evaluation:
  - ext = state in {EXT, EXT_BRK}.
  - brk = state in {BRK, EXT_BRK}.
  - Key i matches when `scan_code == key_codes[i]` and `key_ext[i] == ext`.
- Make on a matching key: set `key_down[i]`. Pulse `press_tick[i]` only if `key_down[i]` was 0; typematic repeats are suppressed.
- Break on a matching key: clear `key_down[i]`. Pulse `release_tick[i]` only if `key_down[i]` was 1.
- Multiple entries with identical code/ext all update together.
- Unmatched code bytes change no key state.
- A change to `key_codes` while a key is held does not clear that key. It clears only when a break arrives for the new code.

## Timing
- Reset (`reset_n` low at a `clk` edge):
  - FSM goes to IDLE.
  - `key_down`, `press_tick`, `release_tick` and `any_down` all go to 0.
  - Takes priority over a coincident `scan_done_tick`.
- Reset mid-sequence (after E0 or F0) discards the prefix. The next code byte is treated as a make.
- Latency: a code byte with `scan_done_tick` in cycle N gives updated `key_down` and the event pulses in cycle N+1. `any_down` updates in cycle N+2.
- Prefix bytes produce no output change.
- Pulses last exactly one cycle, even if `scan_done_tick` is held high on consecutive cycles. Each asserted cycle is treated as a separate byte.
- `press_tick[i]` and `release_tick[i]` are never high in the same cycle.

## Configuration
- `PS2_TYPEMATIC_EN` defined: `press_tick[i]` also pulses on every repeated make of an already-held key. `key_down` behaviour is unchanged.
- `PS2_TYPEMATIC_EN` undefined: only the 0-to-1 make transition pulses, as described in Operation.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT_PREFIX` = 8'hE0 and `PS2_BREAK_PREFIX` = 8'hF0.
  - The prefix-state enum (IDLE/EXT/BRK/EXT_BRK).
  - `PS2_MAX_KEYS` = 16.
- Sub-module `ps2_prefix_fsm` holds the prefix FSM. Outputs: `code_valid` (one cycle), `code_ext`, `code_brk`, `code_byte`.
- The top level holds the per-key match/update array, generated over `NUM_KEYS`.

## Test plan
- Setup for all cases: `NUM_KEYS` = 4, `key_codes` = {8'h75, 8'h23, 8'h1C, 8'h1D}, `key_ext` = 4'b1000 (key 3 is up-arrow).
- Bytes 1D, then F0 1D: `key_down[0]` rises one cycle after the 1D tick, with a single `press_tick[0]`. It falls after the final 1D, with a single `release_tick[0]`. `any_down` follows one cycle later.
- Byte 75 without prefix: no change. Bytes E0 75: `key_down[3]` = 1. Bytes E0 F0 75: `key_down[3]` = 0 and `release_tick[3]` pulses.
- Bytes 1C 1C 1C: `key_down[1]` = 1 and `press_tick[1]` pulses once. With `PS2_TYPEMATIC_EN` defined, it pulses three times.
- Bytes 1D then 1C held, then F0 1C: `key_down` goes 0001, then 0011, then 0001. Unrelated code 8'h2B: no change.
- Byte E0, reset pulse, then 75: the prefix is lost and `key_down` stays 0.
- Bytes F0 F0 1D with key 0 held: releases key 0 once.
- Byte F0, then E0 75: treated as an extended make, so `key_down[3]` = 1.
